// File: rtl/div_strobe_pkg.sv
// Shared types for the divider strobe selector.
// State enum and tap-select width helper.
package div_strobe_pkg;

    typedef enum logic {
        RUN,
        WAIT_ALIGN
    } state_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tap_edge_detect.sv
// Registers divider tap levels and reports per-tap rise/fall.
// Reusable by any consumer of the binary divider taps.
module tap_edge_detect #(
    parameter int NUM_TAPS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_TAPS-1:0] taps,
    output logic [NUM_TAPS-1:0] rise,
    output logic [NUM_TAPS-1:0] fall
);

    logic [NUM_TAPS-1:0] taps_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps;
        end
    end

    assign rise = taps & ~taps_q;
    assign fall = taps_q & ~taps;

endmodule

// File: rtl/div_strobe_sel.sv
// Clock-enable strobe generator on a selectable divider tap.
// Optional strobe counter built when DIV_STROBE_CNT_EN is defined.
module div_strobe_sel
    import div_strobe_pkg::*;
#(
    parameter int NUM_TAPS  = 4,
    parameter int CNT_WIDTH = 16,
    parameter int RESET_SEL = 0
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [NUM_TAPS-1:0]           div_taps,
    input  logic                          sel_req,
    input  logic [sel_w(NUM_TAPS)-1:0]    sel_val,
    output logic                          sel_ack,
    output logic                          busy,
    output logic [sel_w(NUM_TAPS)-1:0]    active_sel,
    output logic                          strobe,
    output logic [CNT_WIDTH-1:0]          strobe_cnt
);

    localparam int SEL_W = sel_w(NUM_TAPS);
    localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);

    logic [NUM_TAPS-1:0] rise;
    logic [NUM_TAPS-1:0] fall;

    state_t            state, state_d;
    logic [SEL_W-1:0]  pend_sel, pend_d;
    logic [SEL_W-1:0]  max_sel, max_d;
    logic [SEL_W-1:0]  active_d;
    logic              ack_d;
    logic              busy_d;
    logic              hit;

    tap_edge_detect #(
        .NUM_TAPS (NUM_TAPS)
    ) u_edge (
        .clk   (clk),
        .n_rst (n_rst),
        .taps  (div_taps),
        .rise  (rise),
        .fall  (fall)
    );

    assign hit = rise[active_sel];

    always_comb begin
        state_d  = state;
        pend_d   = pend_sel;
        max_d    = max_sel;
        active_d = active_sel;
        ack_d    = 1'b0;
        busy_d   = busy;
        unique case (state)
            RUN: begin
                if (sel_req) begin
                    if (sel_val == active_sel) begin
                        ack_d = 1'b1;
                    end else begin
                        pend_d  = sel_val;
                        max_d   = (sel_val > active_sel) ? sel_val : active_sel;
                        busy_d  = 1'b1;
                        state_d = WAIT_ALIGN;
                    end
                end
            end
            WAIT_ALIGN: begin
                // fall on the slowest involved tap means all lower taps are 0
                if (fall[max_sel]) begin
                    active_d = pend_sel;
                    ack_d    = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= RUN;
            pend_sel   <= RST_SEL;
            max_sel    <= RST_SEL;
            active_sel <= RST_SEL;
            sel_ack    <= 1'b0;
            busy       <= 1'b0;
            strobe     <= 1'b0;
        end else begin
            state      <= state_d;
            pend_sel   <= pend_d;
            max_sel    <= max_d;
            active_sel <= active_d;
            sel_ack    <= ack_d;
            busy       <= busy_d;
            strobe     <= hit;
        end
    end

`ifdef DIV_STROBE_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (hit) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign strobe_cnt = cnt_q;
`else
    assign strobe_cnt = '0;
`endif

endmodule
